fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL take parameter RESET_PC, default 0: byte address driven on counter after reset.
REQ-002 The block SHALL take parameter MEM_BYTES, default 512: instruction memory size in bytes; legal fetch addresses are 0..MEM_BYTES-4, word aligned.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port stall, input, 1 bit: downstream hold request.
REQ-006 The block SHALL have port jump, input, 1 bit: J redirect request.
REQ-007 The block SHALL have port jump_target, input, 26 bits: J word index.
REQ-008 The block SHALL have port branch_taken, input, 1 bit: resolved taken BEQ.
REQ-009 The block SHALL have port branch_base, input, 32 bits: PC+4 of the branch.
REQ-010 The block SHALL have port branch_offset, input, 16 bits: signed word offset.
REQ-011 The block SHALL have port instruction, input, 32 bits: combinational word returned by instruction memory for the current counter.
REQ-012 The block SHALL have port counter, output, 32 bits: current PC, byte address, driven to instruction memory.
REQ-013 The block SHALL have port if_instruction, output, 32 bits: registered fetched word.
REQ-014 The block SHALL have port if_pc_plus4, output, 32 bits: registered counter+4 of the fetched word.
REQ-015 The block SHALL have port if_valid, output, 1 bit: if_instruction/if_pc_plus4 hold a real instruction.
REQ-016 The block SHALL have port fetch_fault, output, 1 bit: sticky out-of-range fetch flag.

Function
REQ-017 The FSM SHALL have states BOOT, RUN and FAULT; reset enters BOOT; BOOT goes to RUN after one cycle; RUN goes to FAULT per REQ-024; FAULT is left only by reset.
REQ-018 Next-PC priority in RUN SHALL be jump > branch_taken > stall > sequential.
REQ-019 jump SHALL set the next PC to {counter[31:28], jump_target, 2'b00}; e.g. target 32 gives 128.
REQ-020 branch_taken SHALL set the next PC to branch_base + (sign-extended branch_offset << 2), computed modulo 2^32.
REQ-021 The sequential case SHALL set the next PC to counter + 4.
REQ-022 stall without redirect SHALL hold counter, if_instruction, if_pc_plus4 and if_valid unchanged.
REQ-023 A jump or taken branch SHALL clear if_valid on the same edge that loads the target: one bubble, and the squashed word is never marked valid; any simultaneous stall is ignored.
REQ-024 A next PC >= MEM_BYTES SHALL not be loaded; instead counter holds, if_valid goes 0, fetch_fault goes 1 and the FSM enters FAULT.
REQ-025 In FAULT, counter, if_instruction and if_pc_plus4 SHALL hold, if_valid SHALL be 0 and fetch_fault SHALL be 1, regardless of stall, jump or branch.
REQ-026 In RUN with no stall, no redirect and no fault, each edge SHALL capture instruction into if_instruction, counter+4 into if_pc_plus4, and set if_valid to 1: one-cycle fetch latency.
REQ-027 In BOOT, if_valid SHALL be 0, counter SHALL hold RESET_PC, and stall, jump and branch SHALL be ignored.

Reset
REQ-028 reset high at a rising edge SHALL set counter to RESET_PC, if_instruction to 0, if_pc_plus4 to 0, if_valid to 0, fetch_fault to 0 and the FSM to BOOT, overriding all other inputs including mid-stall, mid-redirect or FAULT.
REQ-029 Outputs SHALL not change asynchronously with reset.

Verification
REQ-030 Reset, then release with no requests -> counter 0 (BOOT), 0, 4, 8; if_valid first high with if_pc_plus4 = 4, if_instruction = word at 0.
REQ-031 At counter 52, jump=1 with jump_target=32 -> next counter 128, if_valid 0 for one cycle, then the word at 128 valid with if_pc_plus4 132.
REQ-032 branch_taken with branch_base 136 and offset 15 -> counter 196; with branch_base 8 and offset 0xFFFF -> counter 4.
REQ-033 stall held 3 cycles at counter 20 -> counter and if_* unchanged; stall together with jump to 0 -> redirect taken, stall ignored.
REQ-034 MEM_BYTES 512, sequential fetch reaching counter 508 -> next edge fetch_fault 1, counter stays 508, if_valid 0; a later jump is ignored; reset -> fetch_fault 0, counter 0.
REQ-035 jump and branch_taken asserted in the same cycle -> jump target loaded; reset asserted in the same cycle as a jump -> counter RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the PC to instruction memory and registers the returned word.
// One-cycle fetch latency; stall holds everything; a redirect costs one bubble; an out-of-range PC is a sticky fault.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'd0,
  parameter int          MEM_BYTES = 512
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        jump,
  input  logic [25:0] jump_target,
  input  logic        branch_taken,
  input  logic [31:0] branch_base,
  input  logic [15:0] branch_offset,
  input  logic [31:0] instruction,
  output logic [31:0] counter,
  output logic [31:0] if_instruction,
  output logic [31:0] if_pc_plus4,
  output logic        if_valid,
  output logic        fetch_fault
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_t;

  localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

  state_t      state;
  logic [31:0] pc_plus4;
  logic [31:0] branch_pc;
  logic [31:0] next_pc;
  logic        redirect;
  logic        out_of_range;

  assign pc_plus4  = counter + 32'd4;
  assign branch_pc = branch_base + {{14{branch_offset[15]}}, branch_offset, 2'b00};
  assign redirect  = jump | branch_taken;

  // Priority: jump over branch over stall over sequential fetch.
  always_comb begin
    next_pc = pc_plus4;
    if (jump)
      next_pc = {counter[31:28], jump_target, 2'b00};
    else if (branch_taken)
      next_pc = branch_pc;
    else if (stall)
      next_pc = counter;
  end

  assign out_of_range = (next_pc >= MEM_LIMIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= BOOT;
      counter        <= RESET_PC;
      if_instruction <= 32'd0;
      if_pc_plus4    <= 32'd0;
      if_valid       <= 1'b0;
      fetch_fault    <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          if_valid <= 1'b0;
          state    <= RUN;
        end
        RUN: begin
          if (out_of_range) begin
            // The offending PC is never presented to memory; counter keeps the last legal value.
            if_valid    <= 1'b0;
            fetch_fault <= 1'b1;
            state       <= FAULT;
          end else if (redirect) begin
            counter  <= next_pc;
            if_valid <= 1'b0;
          end else if (!stall) begin
            counter        <= next_pc;
            if_instruction <= instruction;
            if_pc_plus4    <= pc_plus4;
            if_valid       <= 1'b1;
          end
        end
        FAULT: begin
          if_valid    <= 1'b0;
          fetch_fault <= 1'b1;
        end
        default: begin
          state    <= FAULT;
          if_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; memory returns 0xC0000000 | address so each fetched word identifies its PC.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        jump;
  logic [25:0] jump_target;
  logic        branch_taken;
  logic [31:0] branch_base;
  logic [15:0] branch_offset;
  logic [31:0] instruction;
  logic [31:0] counter;
  logic [31:0] if_instruction;
  logic [31:0] if_pc_plus4;
  logic        if_valid;
  logic        fetch_fault;

  int tests = 0;
  int failed = 0;

  fetch_unit #(.RESET_PC(32'd0), .MEM_BYTES(512)) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .jump           (jump),
    .jump_target    (jump_target),
    .branch_taken   (branch_taken),
    .branch_base    (branch_base),
    .branch_offset  (branch_offset),
    .instruction    (instruction),
    .counter        (counter),
    .if_instruction (if_instruction),
    .if_pc_plus4    (if_pc_plus4),
    .if_valid       (if_valid),
    .fetch_fault    (fetch_fault)
  );

  always #5 clk = ~clk;

  assign instruction = 32'hC000_0000 | counter;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; jump = 1'b0; jump_target = '0;
    branch_taken = 1'b0; branch_base = '0; branch_offset = '0;

    step();
    check("rst_counter", counter, 32'd0);
    check("rst_valid", 32'(if_valid), 32'd0);
    check("rst_fault", 32'(fetch_fault), 32'd0);
    check("rst_instr", if_instruction, 32'd0);
    check("rst_pc4", if_pc_plus4, 32'd0);

    // BOOT cycle must ignore a jump request.
    reset = 1'b0; jump = 1'b1; jump_target = 26'd5;
    step();
    check("boot_counter", counter, 32'd0);
    check("boot_valid", 32'(if_valid), 32'd0);

    jump = 1'b0;
    step();
    check("first_counter", counter, 32'd4);
    check("first_valid", 32'(if_valid), 32'd1);
    check("first_pc4", if_pc_plus4, 32'd4);
    check("first_instr", if_instruction, 32'hC000_0000);
    step();
    check("seq_counter8", counter, 32'd8);
    check("seq_instr4", if_instruction, 32'hC000_0004);
    step(); step(); step();
    check("seq_counter20", counter, 32'd20);

    stall = 1'b1;
    step();
    check("stall1_counter", counter, 32'd20);
    step(); step();
    check("stall3_counter", counter, 32'd20);
    check("stall3_pc4", if_pc_plus4, 32'd20);
    check("stall3_instr", if_instruction, 32'hC000_0010);
    check("stall3_valid", 32'(if_valid), 32'd1);

    jump = 1'b1; jump_target = 26'd0;
    step();
    check("stalljmp_counter", counter, 32'd0);
    check("stalljmp_valid", 32'(if_valid), 32'd0);

    stall = 1'b0; jump = 1'b0;
    step();
    check("after_jmp0_counter", counter, 32'd4);
    check("after_jmp0_pc4", if_pc_plus4, 32'd4);

    jump = 1'b1; jump_target = 26'd13;
    step();
    check("jmp52_counter", counter, 32'd52);
    jump_target = 26'd32;
    step();
    check("jmp128_counter", counter, 32'd128);
    check("jmp128_bubble", 32'(if_valid), 32'd0);
    jump = 1'b0;
    step();
    check("jmp128_valid", 32'(if_valid), 32'd1);
    check("jmp128_pc4", if_pc_plus4, 32'd132);
    check("jmp128_instr", if_instruction, 32'hC000_0080);
    check("jmp128_next", counter, 32'd132);

    branch_taken = 1'b1; branch_base = 32'd136; branch_offset = 16'd15;
    step();
    check("br_fwd_counter", counter, 32'd196);
    check("br_fwd_valid", 32'(if_valid), 32'd0);
    branch_base = 32'd8; branch_offset = 16'hFFFF;
    step();
    check("br_back_counter", counter, 32'd4);

    jump = 1'b1; jump_target = 26'd100; branch_base = 32'd8; branch_offset = 16'd0;
    step();
    check("jmp_over_br", counter, 32'd400);
    jump = 1'b0; branch_taken = 1'b0;
    step();
    check("seq404_counter", counter, 32'd404);
    check("seq404_instr", if_instruction, 32'hC000_0190);

    jump = 1'b1; jump_target = 26'd126;
    step();
    check("jmp504_counter", counter, 32'd504);
    jump = 1'b0;
    step();
    check("top_counter", counter, 32'd508);
    check("top_pc4", if_pc_plus4, 32'd508);
    check("top_valid", 32'(if_valid), 32'd1);
    step();
    check("fault_flag", 32'(fetch_fault), 32'd1);
    check("fault_counter", counter, 32'd508);
    check("fault_valid", 32'(if_valid), 32'd0);
    check("fault_instr_hold", if_instruction, 32'hC000_01F8);
    check("fault_pc4_hold", if_pc_plus4, 32'd508);

    jump = 1'b1; jump_target = 26'd2; stall = 1'b1;
    step();
    check("fault_jmp_counter", counter, 32'd508);
    check("fault_jmp_flag", 32'(fetch_fault), 32'd1);
    check("fault_jmp_valid", 32'(if_valid), 32'd0);

    // Reset in the same cycle as a jump, also clearing the sticky fault.
    reset = 1'b1; stall = 1'b0;
    step();
    check("rstjmp_counter", counter, 32'd0);
    check("rstjmp_fault", 32'(fetch_fault), 32'd0);
    check("rstjmp_instr", if_instruction, 32'd0);
    check("rstjmp_pc4", if_pc_plus4, 32'd0);

    reset = 1'b0; jump = 1'b0;
    step();
    jump = 1'b1; jump_target = 26'd200;
    step();
    check("oob_jmp_counter", counter, 32'd0);
    check("oob_jmp_fault", 32'(fetch_fault), 32'd1);
    check("oob_jmp_valid", 32'(if_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
